// File: rtl/regfile_write_sequencer.sv
// Shares the register file write port between core writeback (priority) and a
// buffered 128-bit AES result written as four words into BASE_ADDR..BASE_ADDR+3.
module regfile_write_sequencer #(
    parameter int BASE_ADDR = 28,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             core_we,
    input  logic [4:0]       core_waddr,
    input  logic [31:0]      core_wdata,
    input  logic             aes_valid,
    input  logic [127:0]     aes_data,
    output logic             aes_ready,
    output logic             write_enable,
    output logic [4:0]       write_addr,
    output logic [31:0]      write_data,
    output logic             aes_busy,
    output logic             aes_done,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    localparam logic [4:0]       BASE     = 5'(BASE_ADDR);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t       state, state_nxt;
    logic [1:0]   idx;
    logic [127:0] data_buf;
    logic         core_claim;
    logic         aes_wr;
    logic [31:0]  aes_word;

    // A core write to x0 is a no-op, so it never takes the port from AES.
    assign core_claim = core_we && (core_waddr != 5'd0);
    assign aes_wr     = (state == WRITE) && !core_claim;
    // Word 0 lives in the top 32 bits; ~idx == 3-idx for a 2-bit index.
    assign aes_word   = data_buf[{~idx, 5'b00000} +: 32];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 2'd0;
            data_buf  <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && aes_valid) begin
                data_buf <= aes_data;
                idx      <= 2'd0;
            end else if (aes_wr) begin
                idx <= idx + 2'd1;
            end
            if (state == WRITE && core_claim && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    always_comb begin
        state_nxt    = state;
        aes_ready    = 1'b0;
        aes_busy     = 1'b0;
        aes_done     = 1'b0;
        write_enable = 1'b0;
        write_addr   = 5'd0;
        write_data   = 32'd0;

        case (state)
            IDLE:    if (aes_valid) state_nxt = WRITE;
            WRITE:   if (aes_wr && idx == 2'd3) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (!reset) begin
            aes_ready = (state == IDLE);
            aes_busy  = (state == WRITE);
            aes_done  = (state == DONE);
            if (core_claim) begin
                write_enable = 1'b1;
                write_addr   = core_waddr;
                write_data   = core_wdata;
            end else if (aes_wr) begin
                write_enable = 1'b1;
                write_addr   = BASE + {3'b000, idx};
                write_data   = aes_word;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Bench for regfile_write_sequencer: directed vector table, hand corner cases,
// and random traffic checked against a queue-based reference model.
module tb_regfile_write_sequencer;
    localparam int BASE_ADDR = 28;
    localparam int CNT_W     = 4;
    localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D2 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;

    logic             clk = 1'b0;
    logic             reset;
    logic             core_we;
    logic [4:0]       core_waddr;
    logic [31:0]      core_wdata;
    logic             aes_valid;
    logic [127:0]     aes_data;
    logic             aes_ready, write_enable, aes_busy, aes_done;
    logic [4:0]       write_addr;
    logic [31:0]      write_data;
    logic [CNT_W-1:0] stall_cnt;

    regfile_write_sequencer #(.BASE_ADDR(BASE_ADDR), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata),
        .aes_valid(aes_valid), .aes_data(aes_data), .aes_ready(aes_ready),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .aes_busy(aes_busy), .aes_done(aes_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // Output bundle: {ready, busy, done, we, addr, data, stall}
    typedef logic [44:0] obs_t;
    obs_t act;

    // Reference model: pending AES words as a queue of {addr, data}.
    logic [36:0] mq[$];
    bit          m_done;
    int          m_stall;
    bit          m_ready;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        ntests++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic obs_t pack(input logic r, b, d, we, input logic [4:0] ad,
                                  input logic [31:0] wd, input logic [CNT_W-1:0] st);
        return {r, b, d, we, ad, wd, st};
    endfunction

    task automatic cyc(input logic cwe, input logic [4:0] cad, input logic [31:0] cwd,
                       input logic vld, input logic [127:0] dat, input logic rst);
        obs_t e;
        logic claim;
        @(negedge clk);
        core_we = cwe; core_waddr = cad; core_wdata = cwd;
        aes_valid = vld; aes_data = dat; reset = rst;
        #1;
        claim   = cwe && cad != 5'd0;
        m_ready = (mq.size() == 0) && !m_done;
        if (rst)
            e = pack(0, 0, 0, 0, 5'd0, 32'd0, CNT_W'(m_stall));
        else if (claim)
            e = pack(m_ready, mq.size() != 0, m_done, 1, cad, cwd, CNT_W'(m_stall));
        else if (mq.size() != 0)
            e = pack(0, 1, 0, 1, mq[0][36:32], mq[0][31:0], CNT_W'(m_stall));
        else
            e = pack(m_ready, 0, m_done, 0, 5'd0, 32'd0, CNT_W'(m_stall));
        act = pack(aes_ready, aes_busy, aes_done, write_enable, write_addr, write_data, stall_cnt);
        chk("model", 64'(act), 64'(e));
    endtask

    task automatic tick();
        bit dn_now;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_done  = 0;
            m_stall = 0;
        end else begin
            dn_now = 0;
            if (mq.size() != 0) begin
                if (core_we && core_waddr != 5'd0) begin
                    if (m_stall < (1 << CNT_W) - 1) m_stall++;
                end else begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) dn_now = 1;
                end
            end
            m_done = dn_now;
            if (m_ready && aes_valid)
                for (int i = 0; i < 4; i++)
                    mq.push_back({5'(BASE_ADDR + i), 32'(aes_data >> (96 - 32 * i))});
        end
    endtask

    typedef struct {
        logic         cwe;
        logic [4:0]   cad;
        logic [31:0]  cwd;
        logic         vld;
        logic [127:0] dat;
        logic         rdy, bsy, dn, we;
        logic [4:0]   ad;
        logic [31:0]  wd;
        logic [3:0]   st;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset = 1; core_we = 0; core_waddr = 0; core_wdata = 0; aes_valid = 0; aes_data = 0;
        @(posedge clk); @(posedge clk);

        // idle, then D1 with aes_valid held high (D2 accepted only at N+6)
        tbl.push_back('{0, 0, 0,            0, 0,  1, 0, 0, 0, 0,  0,            0});
        tbl.push_back('{0, 0, 0,            1, D1, 1, 0, 0, 0, 0,  0,            0});
        tbl.push_back('{0, 0, 0,            1, D2, 0, 1, 0, 1, 28, 32'h00112233, 0});
        tbl.push_back('{0, 0, 0,            1, D2, 0, 1, 0, 1, 29, 32'h44556677, 0});
        tbl.push_back('{0, 0, 0,            1, D2, 0, 1, 0, 1, 30, 32'h8899AABB, 0});
        tbl.push_back('{0, 0, 0,            1, D2, 0, 1, 0, 1, 31, 32'hCCDDEEFF, 0});
        tbl.push_back('{0, 0, 0,            1, D2, 0, 0, 1, 0, 0,  0,            0});
        tbl.push_back('{0, 0, 0,            1, D2, 1, 0, 0, 0, 0,  0,            0});
        tbl.push_back('{0, 0, 0,            0, 0,  0, 1, 0, 1, 28, 32'hA0A1A2A3, 0});
        tbl.push_back('{0, 0, 0,            0, 0,  0, 1, 0, 1, 29, 32'hB0B1B2B3, 0});
        tbl.push_back('{0, 0, 0,            0, 0,  0, 1, 0, 1, 30, 32'hC0C1C2C3, 0});
        tbl.push_back('{0, 0, 0,            0, 0,  0, 1, 0, 1, 31, 32'hD0D1D2D3, 0});
        tbl.push_back('{0, 0, 0,            0, 0,  0, 0, 1, 0, 0,  0,            0});
        tbl.push_back('{0, 0, 0,            0, 0,  1, 0, 0, 0, 0,  0,            0});
        // core stalls the sequence twice
        tbl.push_back('{0, 0, 0,            1, D1, 1, 0, 0, 0, 0,  0,            0});
        tbl.push_back('{0, 0, 0,            0, 0,  0, 1, 0, 1, 28, 32'h00112233, 0});
        tbl.push_back('{1, 5, 32'hDEADBEEF, 0, 0,  0, 1, 0, 1, 5,  32'hDEADBEEF, 0});
        tbl.push_back('{1, 5, 32'hDEADBEEF, 0, 0,  0, 1, 0, 1, 5,  32'hDEADBEEF, 1});
        tbl.push_back('{0, 0, 0,            0, 0,  0, 1, 0, 1, 29, 32'h44556677, 2});
        tbl.push_back('{0, 0, 0,            0, 0,  0, 1, 0, 1, 30, 32'h8899AABB, 2});
        tbl.push_back('{0, 0, 0,            0, 0,  0, 1, 0, 1, 31, 32'hCCDDEEFF, 2});
        tbl.push_back('{0, 0, 0,            0, 0,  0, 0, 1, 0, 0,  0,            2});
        tbl.push_back('{0, 0, 0,            0, 0,  1, 0, 0, 0, 0,  0,            2});
        // core write to x0 does not block AES
        tbl.push_back('{0, 0, 0,            1, D1, 1, 0, 0, 0, 0,  0,            2});
        tbl.push_back('{1, 0, 32'hFFFFFFFF, 0, 0,  0, 1, 0, 1, 28, 32'h00112233, 2});
        tbl.push_back('{0, 0, 0,            0, 0,  0, 1, 0, 1, 29, 32'h44556677, 2});
        tbl.push_back('{0, 0, 0,            0, 0,  0, 1, 0, 1, 30, 32'h8899AABB, 2});
        tbl.push_back('{0, 0, 0,            0, 0,  0, 1, 0, 1, 31, 32'hCCDDEEFF, 2});
        tbl.push_back('{0, 0, 0,            0, 0,  0, 0, 1, 0, 0,  0,            2});
        tbl.push_back('{1, 7, 32'h12345678, 0, 0,  1, 0, 0, 1, 7,  32'h12345678, 2});

        foreach (tbl[i]) begin
            cyc(tbl[i].cwe, tbl[i].cad, tbl[i].cwd, tbl[i].vld, tbl[i].dat, 0);
            chk($sformatf("vec%0d", i), 64'(act),
                64'(pack(tbl[i].rdy, tbl[i].bsy, tbl[i].dn, tbl[i].we,
                         tbl[i].ad, tbl[i].wd, tbl[i].st)));
            tick();
        end

        // reset mid-sequence: x28 lands, the rest is dropped, no done pulse
        cyc(0, 0, 0, 1, D1, 0); tick();
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_x28", {59'd0, write_enable, write_addr}, {59'd0, 1'b1, 5'd28});
        tick();
        cyc(1, 9, 32'h55555555, 0, 0, 1);
        chk("rst_forced", 64'(act), 64'({4'b0000, 5'd0, 32'd0, 4'd2}));
        tick();
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_after", 64'(act), 64'(pack(1, 0, 0, 0, 5'd0, 32'd0, 0)));
        tick();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("no_done", {63'd0, aes_done | write_enable}, 64'd0);
            tick();
        end

        // stall counter saturates at all-ones
        cyc(0, 0, 0, 1, D2, 0); tick();
        for (int i = 0; i < 20; i++) begin
            cyc(1, 3, 32'(i), 0, 0, 0); tick();
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("stall_sat", 64'(stall_cnt), 64'hF);
        chk("sat_resume", {27'd0, write_addr, write_data}, {27'd0, 5'd28, 32'hA0A1A2A3});
        tick();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] cad;
            cad = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) cad = 5'd0;
            cyc(1'($urandom_range(0, 1)), cad, $urandom,
                1'($urandom_range(0, 9) < 3),
                {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(0, 99) == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/regfile_write_sequencer.md
# regfile_write_sequencer

Arbitrates the register file's single write port between the RISC-V core writeback path and the AES coprocessor result path. A 128-bit AES result is accepted over a valid/ready handshake, buffered, and written as four 32-bit words into the fixed result window x28..x31, one word per cycle. Core writeback always has priority. The sequencer sits between the core/AES blocks and the register file write inputs (`write_enable`, `write_addr`, `write_data`).

## Interface
- `BASE_ADDR`, default 28: register index of result word 0. Legal range 1..28; the window is `BASE_ADDR`..`BASE_ADDR+3`.
- `CNT_W`, default 16: width of the stall counter.

- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `core_we` in 1: core writeback request.
- `core_waddr` in 5: core writeback register index.
- `core_wdata` in 32: core writeback data.
- `aes_valid` in 1: AES result valid.
- `aes_data` in 128: AES result; `[127:96]` is word 0.
- `aes_ready` out 1: sequencer can accept a result.
- `write_enable` out 1: to register file.
- `write_addr` out 5: to register file.
- `write_data` out 32: to register file.
- `aes_busy` out 1: high while a result is buffered and not fully written.
- `aes_done` out 1: one-cycle pulse after the last word is written.
- `stall_cnt` out `CNT_W`: count of cycles in which an AES write was blocked by the core; saturating.

## Operation
- States:
  - `IDLE`: `aes_ready`=1. On `aes_valid && aes_ready`, latch `aes_data` into `buf`, set `idx`=0, and go to `WRITE`.
  - `WRITE`: one word per cycle when the port is free, then go to `DONE` after `idx`=3 is written.
  - `DONE`: `aes_done`=1 and `aes_ready`=0 for one cycle, then go to `IDLE`.
- Port ownership is combinational and evaluated every cycle:
  - **Core claims the port** when `core_we`=1 and `core_waddr`≠0. Outputs then pass the core request through: `write_enable`=1, `write_addr`=`core_waddr`, `write_data`=`core_wdata`.
  - **AES write** happens when in `WRITE` and the core does not claim the port: `write_enable`=1, `write_addr`=`BASE_ADDR+idx`, `write_data`=`buf[127-32*idx -: 32]`. `idx` increments on this posedge.
  - **Blocked AES write**: in `WRITE` while the core claims the port, `idx` holds and `stall_cnt` increments, saturating at all-ones.
  - **Neither**: `write_enable`=0, `write_addr`=0, `write_data`=0.
- A core write to x0 does not claim the port. It is not forwarded, so the AES write proceeds that cycle.
- If the core writes a window register before AES writes that word, the later AES write overwrites it: the AES result is final. If the core writes a window register after AES wrote it, the core value stands. No ordering enforcement is applied.
- `aes_busy` = (state==`WRITE`).
- `aes_valid` is ignored outside `IDLE`. `aes_data` must be stable only in the accept cycle.

## Timing
- **Reset**, sampled on posedge:
  - state=`IDLE`, `idx`=0, `buf`=0, `stall_cnt`=0.
  - While `reset`=1, the outputs `aes_ready`, `aes_busy`, `aes_done` and `write_enable` are forced to 0, and `write_addr` and `write_data` are forced to 0.
- Core path latency is 0 cycles (combinational pass-through).
- **Accept at cycle N, no conflicts:**
  - AES writes in cycles N+1..N+4 to x28, x29, x30, x31.
  - `aes_done`=1 in N+5.
  - `aes_ready`=1 again in N+6.
- Each blocked cycle delays all remaining writes and `aes_done` by 1 cycle.
- **Reset mid-sequence:** the sequence aborts, remaining words are never written, and there is no `aes_done` pulse.
- `stall_cnt` is cleared only by reset. It does not wrap.
- The register file latches on posedge, so every write-port output must be stable before the posedge of the cycle it belongs to.

## Test plan
1. **Reset, then idle with `core_we`=0.** Expect `write_enable`=0, `aes_ready`=1, `stall_cnt`=0.
2. **Plain AES result.** Accept `aes_data`=0x00112233_44556677_8899AABB_CCDDEEFF at cycle N with no core traffic. Expect x28=0x00112233, x29=0x44556677, x30=0x8899AABB, x31=0xCCDDEEFF in cycles N+1..N+4, `aes_done` in N+5, `aes_ready` in N+6.
3. **Core stalls.** Same result, with the core writing x5=0xDEADBEEF in cycles N+2 and N+3. Expect x5 written in N+2 and N+3, AES words landing in N+1, N+4, N+5, N+6, `aes_done` in N+7, `stall_cnt`=2.
4. **Core write to x0.** In cycle N+1, the core writes x0=0xFFFFFFFF. Expect the AES write to x28 to occur in that cycle and `stall_cnt` unchanged.
5. **Reset mid-sequence.** Assert `reset` in N+2. Expect x28 written and x29..x31 not written, no `aes_done`, `aes_ready`=1 the cycle after reset deasserts, and `stall_cnt`=0.
6. **Back-to-back results.** Hold `aes_valid` high continuously. Expect the second result accepted only in N+6, and `aes_valid` ignored in N+1..N+5.
